// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the register-bank write-port arbiter.
//   ADDR_W / DATA_W / NUM_REGS : geometry of the 32x32 register bank
//   state_t                    : arbiter state (IDLE, BURST)
//   cnt_w()                    : beat-counter width for a given MAX_BURST
package reg_bank_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Counter must hold the value MAX_BURST itself.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/reg_bank_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot (or zero) grant, first set req bit at or above ptr, wrapping
//   idx : binary index of the granted bit (0 when nothing is requested)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end
endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// Multi-beat bursts lock the port to one owner until the last beat or until
// MAX_BURST beats have been taken (forced release).
// Optional: define REG_BANK_R0_BLOCK_EN to make register 0 read-only zero
// (writes to it are accepted, suppressed, and flagged on err_r0).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/last/addr/data   : per-requester write beats (addr/data packed)
//   req_ready                  : one-hot-or-zero accept (combinational)
//   rb_en/write_reg/write_data : registered bank write interface
//   grant_valid, grant_id      : burst lock indication, current/last owner
//   err_r0                     : pulse when a register-0 write is dropped
module reg_bank_wr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = reg_bank_pkg::ADDR_W,
  parameter int DATA_W    = reg_bank_pkg::DATA_W,
  parameter int MAX_BURST = 8,
  parameter int IW        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rb_en,
  output logic [ADDR_W-1:0]         rb_write_reg,
  output logic [DATA_W-1:0]         rb_write_data,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_id,
  output logic                      err_r0
);
  localparam int CW = cnt_w(MAX_BURST);

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, rr_ptr_n, owner, owner_n;
  logic [CW-1:0]   beat_cnt, cnt_n, cnt_inc;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx, acc_id, ptr_inc;
  logic            acc, acc_last, rel, blk, wr_ok;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    if (state == IDLE) req_ready = pick_gnt;
    else               req_ready[owner] = req_valid[owner];
  end

  assign acc_id   = (state == IDLE) ? pick_idx : owner;
  assign acc      = |(req_valid & req_ready);
  assign acc_last = req_last[acc_id];
  assign acc_addr = req_addr[int'(acc_id)*ADDR_W +: ADDR_W];
  assign acc_data = req_data[int'(acc_id)*DATA_W +: DATA_W];
  // beat_cnt is 0 in IDLE, so the same compare covers MAX_BURST=1.
  assign cnt_inc  = beat_cnt + 1'b1;
  assign rel      = acc_last || (cnt_inc == CW'(MAX_BURST));
  assign ptr_inc  = (acc_id == IW'(NUM_REQ - 1)) ? '0 : acc_id + 1'b1;

`ifdef REG_BANK_R0_BLOCK_EN
  assign blk = (acc_addr == '0);
`else
  assign blk = 1'b0;
`endif
  assign wr_ok = acc & ~blk;

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    cnt_n    = beat_cnt;
    if (acc) begin
      if (rel) begin
        state_n  = IDLE;
        rr_ptr_n = ptr_inc;
        cnt_n    = '0;
      end else begin
        state_n  = BURST;
        owner_n  = acc_id;
        cnt_n    = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_en         <= 1'b0;
      rb_write_reg  <= '0;
      rb_write_data <= '0;
      grant_id      <= '0;
    end else begin
      rb_en <= wr_ok;
      if (wr_ok) begin
        rb_write_reg  <= acc_addr;
        rb_write_data <= acc_data;
      end
      if (acc) grant_id <= acc_id;
    end
  end

  assign grant_valid = (state == BURST);

`ifdef REG_BANK_R0_BLOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_r0 <= 1'b0;
    else        err_r0 <= acc & blk;
  end
`else
  assign err_r0 = 1'b0;
`endif
endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed testbench for reg_bank_wr_arbiter (NUM_REQ=4, MAX_BURST=8).
// Inputs change on the falling edge; ready is checked 1ns later, registered
// outputs are checked on the following falling edge.
module tb_reg_bank_wr_arbiter;
  localparam int N = 4, AW = 5, DW = 32, MB = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            rb_en, grant_valid, err_r0;
  logic [AW-1:0]   rb_write_reg;
  logic [DW-1:0]   rb_write_data;
  logic [1:0]      grant_id;
  int checks = 0, errors = 0;

  reg_bank_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rb_en(rb_en), .rb_write_reg(rb_write_reg), .rb_write_data(rb_write_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .err_r0(err_r0)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; clear_all();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_all(); req_addr = '0; req_data = '0;
    #1;
    checks++; if (rb_en !== 1'b0) begin errors++; $display("FAIL reset_rb_en got %b exp 0", rb_en); end
    checks++; if (rb_write_reg !== '0 || rb_write_data !== '0) begin errors++; $display("FAIL reset_addr_data got %0d/%0d exp 0/0", rb_write_reg, rb_write_data); end
    checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0 || err_r0 !== 1'b0) begin errors++; $display("FAIL reset_grant got gv=%b id=%0d err=%b exp 0/0/0", grant_valid, grant_id, err_r0); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 1, 1, 15, 1515);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    @(negedge clk); clear_all();
    checks++; if (rb_en !== 1'b1 || rb_write_reg !== 5'd15 || rb_write_data !== 32'd1515) begin errors++; $display("FAIL single_write got en=%b reg=%0d data=%0d exp 1/15/1515", rb_en, rb_write_reg, rb_write_data); end
    @(negedge clk);
    checks++; if (rb_en !== 1'b0 || rb_write_reg !== 5'd15 || rb_write_data !== 32'd1515) begin errors++; $display("FAIL single_hold got en=%b reg=%0d data=%0d exp 0/15/1515", rb_en, rb_write_reg, rb_write_data); end
  endtask

  task automatic test_rr();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 1, AW'(10 + i), DW'(100 + i));
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % N;
      exp_rdy = 4'(1 << e);
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
      @(negedge clk);
      checks++; if (rb_en !== 1'b1 || rb_write_reg !== AW'(10 + e) || rb_write_data !== DW'(100 + e) || grant_id !== 2'(e)) begin errors++; $display("FAIL rr_write[%0d] got en=%b reg=%0d data=%0d id=%0d exp 1/%0d/%0d/%0d", k, rb_en, rb_write_reg, rb_write_data, grant_id, 10 + e, 100 + e, e); end
    end
    clear_all();
    @(negedge clk);
    checks++; if (rb_en !== 1'b0) begin errors++; $display("FAIL rr_idle got en=%b exp 0", rb_en); end
  endtask

  task automatic test_burst();
    do_reset();
    set_req(1, 1, 0, 5, 111);
    set_req(2, 1, 1, 22, 2222);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL burst_ready1 got %b exp 0010", req_ready); end
    @(negedge clk);
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || rb_write_data !== 32'd111 || rb_en !== 1'b1) begin errors++; $display("FAIL burst_beat1 got gv=%b id=%0d data=%0d en=%b exp 1/1/111/1", grant_valid, grant_id, rb_write_data, rb_en); end
    req_valid[1] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL burst_stall_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    checks++; if (rb_en !== 1'b0 || grant_valid !== 1'b1) begin errors++; $display("FAIL burst_stall got en=%b gv=%b exp 0/1", rb_en, grant_valid); end
    set_req(1, 1, 0, 5, 222);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL burst_ready2 got %b exp 0010", req_ready); end
    @(negedge clk);
    checks++; if (rb_write_data !== 32'd222 || grant_valid !== 1'b1) begin errors++; $display("FAIL burst_beat2 got data=%0d gv=%b exp 222/1", rb_write_data, grant_valid); end
    set_req(1, 1, 1, 5, 333);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL burst_ready3 got %b exp 0010", req_ready); end
    @(negedge clk);
    checks++; if (rb_write_data !== 32'd333 || grant_valid !== 1'b0) begin errors++; $display("FAIL burst_beat3 got data=%0d gv=%b exp 333/0", rb_write_data, grant_valid); end
    req_valid[1] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL burst_next_ready got %b exp 0100", req_ready); end
    @(negedge clk); clear_all();
    checks++; if (grant_id !== 2'd2 || rb_write_reg !== 5'd22 || rb_write_data !== 32'd2222) begin errors++; $display("FAIL burst_next got id=%0d reg=%0d data=%0d exp 2/22/2222", grant_id, rb_write_reg, rb_write_data); end
  endtask

  task automatic test_forced();
    logic exp_gv;
    do_reset();
    for (int b = 1; b <= 10; b++) begin
      set_req(3, 1, (b == 10), 3, DW'(300 + b));
      if (b == 2) set_req(0, 1, 1, 1, 7);
      if (b == 9) begin
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL forced_ready0 got %b exp 0001", req_ready); end
        @(negedge clk);
        checks++; if (grant_id !== 2'd0 || rb_write_data !== 32'd7 || grant_valid !== 1'b0) begin errors++; $display("FAIL forced_req0 got id=%0d data=%0d gv=%b exp 0/7/0", grant_id, rb_write_data, grant_valid); end
        req_valid[0] = 1'b0;
      end
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL forced_ready3[%0d] got %b exp 1000", b, req_ready); end
      @(negedge clk);
      exp_gv = (b != 8 && b != 10);
      checks++; if (rb_write_data !== DW'(300 + b) || grant_id !== 2'd3 || grant_valid !== exp_gv) begin errors++; $display("FAIL forced_beat[%0d] got data=%0d id=%0d gv=%b exp %0d/3/%b", b, rb_write_data, grant_id, grant_valid, 300 + b, exp_gv); end
    end
    clear_all();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, 1, 0, 9, 41);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_ready got %b exp 0100", req_ready); end
    @(negedge clk);
    set_req(2, 1, 0, 9, 42);
    @(negedge clk);
    checks++; if (rb_en !== 1'b1 || grant_valid !== 1'b1 || rb_write_data !== 32'd42) begin errors++; $display("FAIL rmid_beat2 got en=%b gv=%b data=%0d exp 1/1/42", rb_en, grant_valid, rb_write_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rb_en !== 1'b0 || grant_valid !== 1'b0 || grant_id !== 2'd0 || rb_write_data !== 32'd0) begin errors++; $display("FAIL rmid_async got en=%b gv=%b id=%0d data=%0d exp 0/0/0/0", rb_en, grant_valid, grant_id, rb_write_data); end
    set_req(0, 1, 1, 2, 55);
    set_req(2, 1, 1, 9, 43);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ready0 got %b exp 0001", req_ready); end
    @(negedge clk); clear_all();
    checks++; if (grant_id !== 2'd0 || rb_write_data !== 32'd55 || rb_write_reg !== 5'd2) begin errors++; $display("FAIL rmid_win0 got id=%0d data=%0d reg=%0d exp 0/55/2", grant_id, rb_write_data, rb_write_reg); end
  endtask

  task automatic test_r0();
    do_reset();
    set_req(1, 1, 1, 0, 999);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL r0_ready got %b exp 0010", req_ready); end
    @(negedge clk); clear_all();
`ifdef REG_BANK_R0_BLOCK_EN
    checks++; if (rb_en !== 1'b0 || err_r0 !== 1'b1 || rb_write_data !== 32'd0 || grant_id !== 2'd1) begin errors++; $display("FAIL r0_block got en=%b err=%b data=%0d id=%0d exp 0/1/0/1", rb_en, err_r0, rb_write_data, grant_id); end
`else
    checks++; if (rb_en !== 1'b1 || err_r0 !== 1'b0 || rb_write_reg !== 5'd0 || rb_write_data !== 32'd999) begin errors++; $display("FAIL r0_write got en=%b err=%b reg=%0d data=%0d exp 1/0/0/999", rb_en, err_r0, rb_write_reg, rb_write_data); end
`endif
    @(negedge clk);
    checks++; if (err_r0 !== 1'b0 || rb_en !== 1'b0) begin errors++; $display("FAIL r0_after got err=%b en=%b exp 0/0", err_r0, rb_en); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_burst();
    test_forced();
    test_reset_mid();
    test_r0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bank_wr_arbiter.md
Name: reg_bank_wr_arbiter

Overview:
Shares the single write port of the 32x32 register bank among NUM_REQ requesters, using round-robin arbitration with valid/ready handshakes. Supports locked multi-beat bursts, with a forced-release starvation guard. Sits between the execution/writeback sources and the bank's en/write_reg/write_data inputs. The read port is not touched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, write data width
MAX_BURST, 8, maximum beats one owner may hold the port before forced release (1..16)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester write beat valid
req_last  in  NUM_REQ  beat is last of transaction (1 = single-beat write)
req_addr  in  NUM_REQ*ADDR_W  packed register addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
req_ready  out  NUM_REQ  one-hot-or-zero accept, combinational from state and req_valid
rb_en  out  1  registered write enable to bank
rb_write_reg  out  ADDR_W  registered write address to bank
rb_write_data  out  DATA_W  registered write data to bank
grant_valid  out  1  a burst is locked (state BURST)
grant_id  out  $clog2(NUM_REQ)  current/last owner index
err_r0  out  1  one-cycle pulse: a write to register 0 was dropped (see Optional Feature)

Behaviour:
- Reset (async, immediate): state IDLE; rr_ptr=0; owner=0; beat_cnt=0; rb_en=0; rb_write_reg=0; rb_write_data=0; grant_valid=0; grant_id=0; err_r0=0. Reset mid-burst drops rb_en immediately and discards the burst.
- Accept: a beat of requester i is accepted when req_valid[i] & req_ready[i] at a rising edge. At most one req_ready bit is high per cycle.
- Latency: a beat accepted at edge N drives rb_en=1, rb_write_reg and rb_write_data from edge N until edge N+1, so the bank writes at edge N+1. Back-to-back beats give rb_en=1 continuously. With no accept, rb_en=0 and addr/data hold their previous values.
- IDLE:
  - Winner = first valid requester scanning from rr_ptr upward, wrapping modulo NUM_REQ. req_ready[winner]=1.
  - If the accepted beat has last=1: stay in IDLE, rr_ptr=winner+1 (mod NUM_REQ).
  - If last=0: go to BURST, owner=winner, beat_cnt=1, grant_valid=1, grant_id=winner.
- BURST:
  - req_ready[owner]=req_valid[owner]; all other requesters get ready=0. The owner deasserting valid stalls the burst; there is no timeout.
  - Each accepted beat increments beat_cnt.
  - Return to IDLE when the accepted beat has last=1 or beat_cnt reaches MAX_BURST (forced release; remaining beats re-arbitrate as a new transaction). On return, rr_ptr=owner+1 and grant_valid=0.
- grant_id updates on every accept and holds otherwise.
- rr_ptr wraps from NUM_REQ-1 to 0.
- MAX_BURST=1: every beat is treated as last.
- Requester payload may change freely while ready=0. It is sampled only on accept.

Optional Feature:
Macro REG_BANK_R0_BLOCK_EN.
- Defined: register 0 is read-only zero. A beat with address 0 is still accepted and counts toward the burst, but rb_en=0 for its cycle, rb_write_reg/rb_write_data hold, and err_r0 pulses 1 for that cycle.
- Undefined: address 0 is written like any other register; err_r0 is tied 0.

Decomposition:
- Package reg_bank_pkg: ADDR_W, DATA_W, NUM_REGS=32 constants; state enum {IDLE, BURST}; beat counter width derived from MAX_BURST.
- Sub-module rr_pick: combinational round-robin picker with inputs req vector and pointer, outputs one-hot grant and index. Reused by future read-port sharing.

Test Plan:
- Reset, then requester 0 writes a single beat (addr 15, data 1515, last=1) -> ready[0] same cycle; next cycle rb_en=1, rb_write_reg=15, rb_write_data=1515; cycle after, rb_en=0.
- Requesters 0..3 all valid with single beats (addr 10+i, data 100+i) -> grants in order 0,1,2,3, one per cycle. rr_ptr wraps; the next round starts at 0.
- Requester 1 sends a 3-beat burst (data 111,222,333) while requester 2 is valid -> grant_valid=1; ready[2]=0 until requester 1's last beat; requester 2 is granted the following cycle.
- Requester 3 sends a 10-beat burst, MAX_BURST=8, requester 0 valid -> forced release after beat 8; requester 0 is granted next; requester 3 resumes beats 9-10 afterward.
- rst_n pulled low mid-burst at beat 2 -> rb_en=0 immediately, state IDLE; after release, requester 0 wins first.
- Write to addr 0, data 999 -> with REG_BANK_R0_BLOCK_EN defined: beat accepted, rb_en=0, err_r0 pulses 1. Without the macro: rb_en=1, rb_write_reg=0, rb_write_data=999.
